// File: rtl/imem_loader.sv
// Program loader: receives a framed byte stream (LEN, 2N data bytes, CHK),
// writes 16-bit words into instruction memory and releases the core on a good checksum.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rstn,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_WR   = 3'd3,
        ST_CHK  = 3'd4,
        ST_RUN  = 3'd5
    } state_t;

    // A LEN byte of zero encodes a full 2^ADDR_W-word image.
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W:0]   cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        sum_r;
    logic [7:0]        hi_r;
    logic              accept_s;

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign accept_s = byte_valid && byte_ready;

    // Frame-parsing state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {(ADDR_W+1){1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            sum_r      <= 8'd0;
            hi_r       <= 8'd0;
            byte_ready <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= {DATA_W{1'b0}};
            core_rstn  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= (byte_data == 8'd0) ? CNT_FULL : (ADDR_W+1)'(byte_data);
                        addr_r   <= {ADDR_W{1'b0}};
                        sum_r    <= byte_data;
                        load_err <= 1'b0;
                        state_r  <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (accept_s) begin
                        hi_r    <= byte_data;
                        sum_r   <= sum8(sum_r, byte_data);
                        state_r <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (accept_s) begin
                        imem_wdata <= {hi_r, byte_data};
                        imem_addr  <= addr_r;
                        imem_we    <= 1'b1;
                        byte_ready <= 1'b0;
                        sum_r      <= sum8(sum_r, byte_data);
                        state_r    <= ST_WR;
                    end
                end
                ST_WR: begin
                    imem_we    <= 1'b0;
                    byte_ready <= 1'b1;
                    addr_r     <= addr_r + ADDR_ONE;
                    cnt_r      <= cnt_r - CNT_ONE;
                    state_r    <= (cnt_r == CNT_ONE) ? ST_CHK : ST_HI;
                end
                ST_CHK: begin
                    if (accept_s) begin
                        if (sum8(sum_r, byte_data) == 8'd0) begin
                            byte_ready <= 1'b0;
                            core_rstn  <= 1'b1;
                            load_done  <= 1'b1;
                            state_r    <= ST_RUN;
                        end else begin
                            load_err <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    byte_ready <= 1'b0;
                    core_rstn  <= 1'b1;
                    load_done  <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    byte_ready <= 1'b1;
                    imem_we    <= 1'b0;
                    core_rstn  <= 1'b0;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
